// File: rtl/fir_sparse_mac_q15_if.sv
// Stream, configuration and status bundle for fir_sparse_mac_q15.
// The master side is the sample source / result sink, the slave side is the filter.
interface fir_sparse_mac_q15_if #(
    parameter int IN_W   = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 7,
    parameter int AW     = 5
);
    logic                     cfg_we;
    logic [AW-1:0]            cfg_addr;
    logic signed [COEF_W-1:0] cfg_coef;
    logic [IDX_W-1:0]         cfg_idx;

    logic signed [IN_W-1:0]   in_data;
    logic                     in_valid;
    logic                     in_ready;

    logic signed [OUT_W-1:0]  out_data;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_sat;
    logic                     out_valid;
    logic                     out_ready;

    logic                     busy;

    modport master (
        output cfg_we, cfg_addr, cfg_coef, cfg_idx,
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_acc, out_sat, out_valid, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_coef, cfg_idx,
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_acc, out_sat, out_valid, busy
    );
endinterface

// File: rtl/fir_sparse_mac_q15.sv
// Time-multiplexed sparse Q15 FIR: one multiplier walks NZ (coef, delay index) table entries.
// Define FIR_SYMMETRIC_EN for the linear-phase fold (NZ/2 MAC cycles with a pre-adder).
module fir_sparse_mac_q15 #(
    parameter int L      = 65,
    parameter int NZ     = 24,
    parameter int IN_W   = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int FRAC   = 15
) (
    input logic                clk,
    input logic                rst,
    fir_sparse_mac_q15_if.slave bus
);
    localparam int IDX_W = $clog2(L);
    localparam int AW    = $clog2(NZ);

`ifdef FIR_SYMMETRIC_EN
    localparam int MAC_N = NZ / 2;
    localparam int PRE_W = IN_W + 1;
`else
    localparam int MAC_N = NZ;
    localparam int PRE_W = IN_W;
`endif
    localparam int PROD_W = PRE_W + COEF_W;

    localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t state, state_nx;
    logic   busy_q;

    logic   accept, mac_en, drain_en, take, cfg_ok;

    logic signed [IN_W-1:0]   dline    [L];
    logic signed [COEF_W-1:0] coef_tab [NZ];
    logic [IDX_W-1:0]         idx_tab  [NZ];

    logic [AW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [PROD_W-1:0] prod;
    logic                     in_ready_q;

    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [ACC_W-1:0]  out_acc_q;
    logic                     out_sat_q;
    logic                     out_valid_q;

    logic signed [PRE_W-1:0]  pre;
    logic signed [PROD_W-1:0] term;
    logic signed [ACC_W-1:0]  final_sum;
    logic signed [ACC_W:0]    rnd;
    logic signed [ACC_W:0]    shifted;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (k == AW'(MAC_N - 1)) state_nx = DRAIN;
            DRAIN:   state_nx = OUT;
            OUT:     if (take) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        accept   = 1'b0;
        mac_en   = 1'b0;
        drain_en = 1'b0;
        take     = 1'b0;
        cfg_ok   = 1'b0;
        unique case (state)
            IDLE: begin
                accept = bus.in_valid && in_ready_q;
                // Bad index or address drops the whole entry, coefficient included.
                cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < 32'(L)) && (32'(bus.cfg_addr) < 32'(NZ));
            end
            MAC:     mac_en   = 1'b1;
            DRAIN:   drain_en = 1'b1;
            OUT:     take     = bus.out_ready && out_valid_q;
            default: ;
        endcase
    end

    // ------------------------------------------------------ storage
    // NOTE: the delay line and tables are reset explicitly; a reset must leave
    // the filter with a zero history and an all-zero tap table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L; i++) dline[i] <= '0;
        end else if (accept) begin
            dline[0] <= bus.in_data;
            for (int i = 1; i < L; i++) dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NZ; i++) begin
                coef_tab[i] <= '0;
                idx_tab[i]  <= '0;
            end
        end else if (cfg_ok) begin
            coef_tab[bus.cfg_addr] <= bus.cfg_coef;
            idx_tab[bus.cfg_addr]  <= bus.cfg_idx;
        end
    end

    // ------------------------------------------------------ datapath
`ifdef FIR_SYMMETRIC_EN
    logic [AW-1:0] k_mir;
    always_comb begin
        k_mir = AW'(NZ - 1) - k;
        pre   = PRE_W'(dline[idx_tab[k]]) + PRE_W'(dline[idx_tab[k_mir]]);
    end
`else
    always_comb pre = dline[idx_tab[k]];
`endif

    always_comb begin
        term      = PROD_W'(pre) * PROD_W'(coef_tab[k]);
        final_sum = acc + ACC_W'(prod);
        // One guard bit so the rounding constant cannot wrap the sum.
        rnd       = (ACC_W + 1)'(final_sum) + HALF;
        shifted   = rnd >>> FRAC;
    end

    // Product is pipelined one cycle ahead of the accumulator; DRAIN adds the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k    <= '0;
            acc  <= '0;
            prod <= '0;
        end else if (accept) begin
            k    <= '0;
            acc  <= '0;
            prod <= '0;
        end else if (mac_en) begin
            k    <= k + 1'b1;
            acc  <= acc + ACC_W'(prod);
            prod <= term;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_acc_q   <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (accept) in_ready_q <= 1'b0;
            if (drain_en) begin
                out_acc_q   <= final_sum;
                out_valid_q <= 1'b1;
                if (shifted > OUT_MAX) begin
                    out_data_q <= OUT_MAX[OUT_W-1:0];
                    out_sat_q  <= 1'b1;
                end else if (shifted < OUT_MIN) begin
                    out_data_q <= OUT_MIN[OUT_W-1:0];
                    out_sat_q  <= 1'b1;
                end else begin
                    out_data_q <= shifted[OUT_W-1:0];
                    out_sat_q  <= 1'b0;
                end
            end
            if (take) begin
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fir_sparse_mac_q15.sv
// Scoreboard bench for fir_sparse_mac_q15: a direct-form reference model predicts each
// result at accept time; results are popped and compared when out_valid is seen.
module tb_fir_sparse_mac_q15;
    localparam int L      = 65;
    localparam int NZ     = 24;
    localparam int ACC_W  = 40;
    localparam int FRAC   = 15;
    localparam int IDX_W  = $clog2(L);
    localparam int AW     = $clog2(NZ);
    localparam int BOUND  = 200;
`ifdef FIR_SYMMETRIC_EN
    localparam int LAT = NZ / 2 + 1;
`else
    localparam int LAT = NZ + 1;
`endif

    typedef struct {
        longint acc;
        longint data;
        longint sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_sparse_mac_q15_if bus ();

    fir_sparse_mac_q15 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     errors = 0;
    int     checks = 0;
    longint m_dline [L];
    longint m_coef  [NZ];
    int     m_idx   [NZ];
    exp_t   sb[$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < L; i++) m_dline[i] = 0;
        for (int i = 0; i < NZ; i++) begin
            m_coef[i] = 0;
            m_idx[i]  = 0;
        end
        sb.delete();
    endtask

    task automatic model_write(input int a, input logic signed [15:0] c, input int ix);
        if (ix < L && a < NZ) begin
            m_coef[a] = c;
            m_idx[a]  = ix;
        end
    endtask

    task automatic model_push(input logic signed [15:0] x);
        exp_t   e;
        longint f, ce, r;
        for (int i = L - 1; i > 0; i--) m_dline[i] = m_dline[i-1];
        m_dline[0] = x;
        f = 0;
        for (int kk = 0; kk < NZ; kk++) begin
`ifdef FIR_SYMMETRIC_EN
            ce = (kk < NZ / 2) ? m_coef[kk] : m_coef[NZ-1-kk];
`else
            ce = m_coef[kk];
`endif
            f += m_dline[m_idx[kk]] * ce;
        end
        r = (f + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        e.acc = f;
        if (r > 32767) begin
            e.data = 32767;  e.sat = 1;
        end else if (r < -32768) begin
            e.data = -32768; e.sat = 1;
        end else begin
            e.data = r;      e.sat = 0;
        end
        sb.push_back(e);
    endtask

    task automatic cfg_write(input int a, input logic signed [15:0] c, input int ix);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_coef = c;
        bus.cfg_idx  = IDX_W'(ix);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        model_write(a, c, ix);
    endtask

    task automatic send(input logic signed [15:0] x, input bit with_cfg,
                        input int a, input logic signed [15:0] c, input int ix);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= BOUND) check("in_ready_timeout", 0, 1);
        bus.in_data  = x;
        bus.in_valid = 1'b1;
        if (with_cfg) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(a);
            bus.cfg_coef = c;
            bus.cfg_idx  = IDX_W'(ix);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        if (with_cfg) model_write(a, c, ix);
        model_push(x);
        check("in_ready_after_accept", bus.in_ready, 0);
        check("busy_after_accept", bus.busy, 1);
    endtask

    // Counts edges from the accept edge; pokes in_valid (and optionally cfg_we) mid-MAC.
    task automatic wait_out(input bit lock_wr, output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < BOUND) begin
            bus.in_valid = (lat == 3);
            bus.in_data  = 16'sh5555;
            bus.cfg_we   = lock_wr && (lat == 2);
            bus.cfg_addr = '0;
            bus.cfg_coef = 16'sh7FFF;
            bus.cfg_idx  = '0;
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        bus.cfg_we   = 1'b0;
        if (lat >= BOUND) check("out_valid_timeout", 0, 1);
    endtask

    task automatic receive(input int hold, input bit lock_wr,
                           output longint o_acc, output longint o_data, output longint o_sat);
        exp_t e;
        int   lat;
        wait_out(lock_wr, lat);
        check("latency", lat, LAT);
        o_acc  = bus.out_acc;
        o_data = bus.out_data;
        o_sat  = bus.out_sat;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
            e.acc = 0; e.data = 0; e.sat = 0;
        end else begin
            e = sb.pop_front();
        end
        check("out_acc", bus.out_acc, e.acc);
        check("out_data", bus.out_data, e.data);
        check("out_sat", bus.out_sat, e.sat);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 16'sh1357;
            @(posedge clk); #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_out_acc", bus.out_acc, e.acc);
            check("hold_out_data", bus.out_data, e.data);
            check("hold_out_sat", bus.out_sat, e.sat);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_handshake", bus.out_valid, 0);
        check("in_ready_after_handshake", bus.in_ready, 1);
        check("busy_after_handshake", bus.busy, 0);
    endtask

    initial begin
        longint a, d, s;
        int     seen;
        rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_coef = '0; bus.cfg_idx = '0;
        bus.in_data = '0;  bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_acc", bus.out_acc, 0);
        check("rst_out_sat", bus.out_sat, 0);

        // impulse / scale
        cfg_write(0, 16'sh4000, 0);
        send(16'sh2000, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
`ifndef FIR_SYMMETRIC_EN
        check("impulse_acc", a, 64'sh0800_0000);
        check("impulse_data", d, 64'sh1000);
        check("impulse_sat", s, 0);
`endif

        // rounding half-up
        cfg_write(0, 16'sh0001, 0);
        send(16'sh4000, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
        send(16'sh3FFF, 0, 0, 0, 0);
        receive(0, 0, a, d, s);

        // saturation both ways
        cfg_write(0, 16'sh7FFF, 0);
        cfg_write(1, 16'sh7FFF, 1);
        send(16'sh7FFF, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
        send(16'sh7FFF, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
        check("sat_pos_data", d, 32767);
        check("sat_pos_flag", s, 1);
        send(-16'sh8000, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
        send(-16'sh8000, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
        check("sat_neg_data", d, -32768);
        check("sat_neg_flag", s, 1);

        // backpressure: pulsed in_valid while held must not shift history
        cfg_write(0, 16'sh0100, 0);
        cfg_write(1, -16'sh0200, 1);
        send(16'sh1000, 0, 0, 0, 0);
        receive(10, 0, a, d, s);
        send(16'sh0100, 0, 0, 0, 0);
        receive(0, 0, a, d, s);

        // config write during MAC is ignored for this and the next result
        send(16'sh2000, 0, 0, 0, 0);
        receive(0, 1, a, d, s);
        send(16'sh0400, 0, 0, 0, 0);
        receive(0, 0, a, d, s);

        // out-of-range index / address writes are dropped entirely
        cfg_write(2, 16'sh4000, L);
        cfg_write(30, 16'sh4000, 0);
        send(16'sh0800, 0, 0, 0, 0);
        receive(0, 0, a, d, s);

        // write coincident with accept is used by that MAC
        send(16'sh0800, 1, 3, 16'sh2000, 1);
        receive(0, 0, a, d, s);

        // reset in the middle of MAC
        send(16'sh2000, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < NZ + 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        check("midrst_no_result", seen, 0);
        cfg_write(0, 16'sh4000, 0);
        send(16'sh2000, 0, 0, 0, 0);
        receive(0, 0, a, d, s);
`ifndef FIR_SYMMETRIC_EN
        check("post_rst_impulse_acc", a, 64'sh0800_0000);
`endif

        // random table, random samples, back-to-back
        for (int i = 0; i < NZ; i++)
            cfg_write(i, 16'($urandom), int'($urandom_range(0, L - 1)));
        for (int n = 0; n < 12; n++) begin
            send(16'($urandom), 0, 0, 0, 0);
            receive(0, 0, a, d, s);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
